core_s1_fetch_ctrl: RTL

- Sequences instruction fetch for core stage 1.
- Owns the PC register and issues one-at-a-time requests on a valid/ready instruction-memory port.
- Squashes in-flight fetches on trap/branch redirects, buffers one fetched instruction for s2 under backpressure, and parks the stage on halt.
- Sits between the s1 PC/redirect inputs, imem, and the s1-to-s2 pipeline register.

---
 rtl/core_s1_fetch_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/core_s1_fetch_ctrl.sv
// Core stage-1 fetch sequencer: owns the PC, issues one-at-a-time imem requests,
// squashes redirected fetches and buffers one instruction for s2.
// Optional perf counters are compiled in with `define LETC_S1_FETCH_PERF_EN.
module core_s1_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        s2_busy,
  input  logic        trap_occurred,
  input  logic [31:0] trap_target_addr,
  input  logic        s2_to_s1_branch_en,
  input  logic [31:0] s2_to_s1_branch_target_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_instr,
  input  logic        imem_rsp_fault,
  output logic        s1_to_s2_valid,
  output logic [31:0] s1_to_s2_pc,
  output logic [31:0] s1_to_s2_instr,
  output logic        s1_to_s2_fetch_fault,
`ifdef LETC_S1_FETCH_PERF_EN
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_squash_count,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_WAIT_RSP = 2'd1,
    S_HALTED   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic        halt_pend_q, halt_pend_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_fault_q, out_fault_d;

  logic        redirect;
  logic        redirect_take;
  logic [31:0] redirect_tgt;
  logic        out_fire;
  logic        req_fire;
  logic        rsp_accept;
  logic        deliver;
  logic        discard;

  // Trap wins over branch; targets are forced word-aligned.
  assign redirect     = trap_occurred | s2_to_s1_branch_en;
  assign redirect_tgt = (trap_occurred ? trap_target_addr : s2_to_s1_branch_target_addr)
                        & 32'hFFFF_FFFC;
  assign out_fire     = out_valid_q & ~s2_busy;
  assign req_fire     = imem_req_valid & imem_req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (req_fire) begin
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (imem_rsp_valid) begin
          state_d = (halt_req | halt_pend_q) ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // FSM outputs; a request is withheld while the output slot cannot drain
  always_comb begin
    imem_req_valid = 1'b0;
    halted         = 1'b0;
    redirect_take  = 1'b0;
    rsp_accept     = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req_valid = rst_n & ~redirect & ~halt_req & (~out_valid_q | ~s2_busy);
        redirect_take  = redirect;
      end
      S_WAIT_RSP: begin
        redirect_take = redirect;
        rsp_accept    = imem_rsp_valid;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        imem_req_valid = 1'b0;
      end
    endcase
  end

  assign imem_req_addr = pc_q;
  assign deliver       = rsp_accept & ~squash_q & ~redirect;
  assign discard       = rsp_accept & ~deliver;

  // PC, squash and halt-pending control
  always_comb begin
    pc_d        = pc_q;
    squash_d    = squash_q;
    halt_pend_d = halt_pend_q;
    if (redirect_take) begin
      pc_d = redirect_tgt;
    end else if (deliver) begin
      pc_d = pc_q + 32'd4;
    end
    if (state_q == S_WAIT_RSP) begin
      if (rsp_accept) begin
        squash_d    = 1'b0;
        halt_pend_d = 1'b0;
      end else begin
        if (redirect) begin
          squash_d = 1'b1;
        end
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
      end
    end
  end

  // s1-to-s2 output register: load beats flush beats consume
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_fault_d = out_fault_q;
    if (deliver) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_q;
      out_instr_d = imem_rsp_fault ? NOP_INSTR : imem_rsp_instr;
      out_fault_d = imem_rsp_fault;
    end else if (redirect_take || out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_instr_q <= NOP_INSTR;
      out_fault_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      halt_pend_q <= halt_pend_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_fault_q <= out_fault_d;
    end
  end

  assign s1_to_s2_valid       = out_valid_q;
  assign s1_to_s2_pc          = out_pc_q;
  assign s1_to_s2_instr       = out_instr_q;
  assign s1_to_s2_fetch_fault = out_fault_q;

`ifdef LETC_S1_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, deliver};
    squash_cnt_d = squash_cnt_q + {31'd0, discard};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign perf_fetch_count  = fetch_cnt_q;
  assign perf_squash_count = squash_cnt_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule
